// File: rtl/hu_stall_ctrl_pkg.sv
// Shared definitions for the hazard-unit stall controller: FSM state encoding
// and parameter defaults.
package hu_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } hu_state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
    localparam int unsigned PERF_W_DEFAULT      = 32;
    localparam int unsigned WAIT_CNT_W          = 16;

endpackage

// File: rtl/hu_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module hu_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            w_count_d = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hu_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait stalls with timeout to a sticky error state, and perf counters.
module hu_stall_ctrl
    import hu_stall_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned PERF_W      = PERF_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        Rs1_D,
    input  logic [4:0]        Rs2_D,
    input  logic              reg_ren_D,
    input  logic              use_rs2_D,
    input  logic [4:0]        Rd_E,
    input  logic              MemRead_E,
    input  logic              RegWrite_E,
    input  logic              branch_taken_E,
    input  logic              mem_req_M,
    input  logic              mem_ready_M,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Stall_M,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              Flush_W,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    hu_state_e             r_state;
    hu_state_e             w_state_d;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_d;

    logic w_lu;
    logic w_mw;
    logic w_stall_fd;
    logic w_stall_em;
    logic w_flush_d;
    logic w_flush_e;
    logic w_flush_w;
    logic w_timeout;

    // Load-use hazard against a real (non-x0) destination.
    assign w_lu = MemRead_E & RegWrite_E & (Rd_E != 5'd0) &
                  ((reg_ren_D & (Rs1_D == Rd_E)) | (use_rs2_D & (Rs2_D == Rd_E)));
    assign w_mw = mem_req_M & ~mem_ready_M;

    assign w_timeout = ({16'd0, r_wait_cnt} + 32'd1) >= MEM_TIMEOUT;

    always_comb begin
        w_state_d  = r_state;
        w_wait_d   = r_wait_cnt;
        w_stall_fd = 1'b0;
        w_stall_em = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        w_flush_w  = 1'b0;

        unique case (r_state)
            StRun, StMemWait: begin
                if (w_mw) begin
                    w_stall_fd = 1'b1;
                    w_stall_em = 1'b1;
                    w_flush_w  = 1'b1;
                    if (r_state == StRun) begin
                        w_state_d = StMemWait;
                        w_wait_d  = '0;
                    end else begin
                        w_wait_d = r_wait_cnt + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                        if (w_timeout) begin
                            w_state_d = StErr;
                        end
                    end
                end else begin
                    // Taken branch squashes the wrong-path D instr, so its
                    // load-use hazard is irrelevant.
                    w_state_d = StRun;
                    w_wait_d  = '0;
                    if (branch_taken_E) begin
                        w_flush_d = 1'b1;
                        w_flush_e = 1'b1;
                    end else if (w_lu) begin
                        w_stall_fd = 1'b1;
                        w_flush_e  = 1'b1;
                    end
                end
            end
            StErr: begin
                w_stall_fd = 1'b1;
                w_stall_em = 1'b1;
                w_flush_w  = 1'b1;
            end
            default: begin
                w_state_d = StRun;
                w_wait_d  = '0;
            end
        endcase

        if (!rst_n) begin
            w_stall_fd = 1'b0;
            w_stall_em = 1'b0;
            w_flush_d  = 1'b0;
            w_flush_e  = 1'b0;
            w_flush_w  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_d;
        end
    end

    assign Stall_F = w_stall_fd;
    assign Stall_D = w_stall_fd;
    assign Stall_E = w_stall_em;
    assign Stall_M = w_stall_em;
    assign Flush_D = w_flush_d;
    assign Flush_E = w_flush_e;
    assign Flush_W = w_flush_w;
    assign mem_err = (r_state == StErr);

    hu_sat_counter #(
        .WIDTH (PERF_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_stall_fd),
        .i_clear (1'b0),
        .o_count (stall_cnt)
    );

    hu_sat_counter #(
        .WIDTH (PERF_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_flush_d | w_flush_e),
        .i_clear (1'b0),
        .o_count (flush_cnt)
    );

endmodule
